// File: rtl/amba_ahb_arbiter.sv
// rtl/amba_ahb_arbiter.sv - round-robin AHB bus arbiter with fixed-burst/lock protection and default-master parking
module amba_ahb_arbiter #(
  parameter int NM = 2,
  parameter int DM = 0,
  localparam int MW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic          i_hclk,
  input  logic          i_hreset,
  input  logic [NM-1:0] i_hbusreq,
  input  logic [NM-1:0] i_hlock,
  input  logic [1:0]    i_htrans,
  input  logic [2:0]    i_hburst,
  input  logic          i_hready,
  output logic [NM-1:0] o_hgrant,
  output logic [MW-1:0] o_hmaster,
  output logic          o_hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;
  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [MW-1:0] DM_IDX = MW'(DM);

  logic [NM-1:0] r_grant;
  logic [MW-1:0] r_owner;
  logic [MW-1:0] r_hmaster;
  logic          r_hmastlock;
  logic [3:0]    r_cnt;

  logic [3:0]    w_len_m1;
  logic          w_owner_req;
  logic          w_owner_lock;
  logic          w_handover;
  logic          w_found;
  logic [MW-1:0] w_next;

  always_comb begin
    w_len_m1 = 4'd0;
    case (i_hburst)
      3'd2, 3'd3: w_len_m1 = 4'd3;
      3'd4, 3'd5: w_len_m1 = 4'd7;
      3'd6, 3'd7: w_len_m1 = 4'd15;
      default:    w_len_m1 = 4'd0;
    endcase
  end

  assign w_owner_req  = i_hbusreq[r_owner];
  assign w_owner_lock = i_hlock[r_owner];

  // BUSY only hands over inside an undefined-length INCR burst; fixed bursts run to their last beat.
  assign w_handover = i_hready && !w_owner_lock &&
                      ((i_htrans == TR_IDLE && r_cnt == 4'd0) ||
                       (i_htrans == TR_NONSEQ && i_hburst == HB_SINGLE) ||
                       (i_htrans == TR_SEQ && r_cnt == 4'd1) ||
                       (i_htrans != TR_IDLE && i_hburst == HB_INCR && !w_owner_req));

  // Search starts just past the owner and wraps back to it, so the owner is served last.
  always_comb begin
    w_next  = DM_IDX;
    w_found = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      if (!w_found && i_hbusreq[(int'(r_owner) + i) % NM]) begin
        w_found = 1'b1;
        w_next  = MW'((int'(r_owner) + i) % NM);
      end
    end
  end

  always_ff @(posedge i_hclk) begin
    if (i_hreset) begin
      r_grant     <= NM'(1) << DM;
      r_owner     <= DM_IDX;
      r_hmaster   <= DM_IDX;
      r_hmastlock <= 1'b0;
      r_cnt       <= 4'd0;
    end else if (i_hready) begin
      r_hmaster   <= r_owner;
      r_hmastlock <= w_owner_lock;
      if (i_htrans == TR_NONSEQ)
        r_cnt <= w_len_m1;
      else if (i_htrans == TR_SEQ && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_handover) begin
        r_grant <= NM'(1) << w_next;
        r_owner <= w_next;
      end
    end
  end

  assign o_hgrant    = r_grant;
  assign o_hmaster   = r_hmaster;
  assign o_hmastlock = r_hmastlock;

endmodule

// File: tb/tb_amba_ahb_arbiter.sv
// tb/tb_amba_ahb_arbiter.sv - directed-vector bench for amba_ahb_arbiter (NM=2, DM=0)
module tb_amba_ahb_arbiter;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] busreq;
  logic [1:0] lock;
  logic [1:0] trans;
  logic [2:0] burst;
  logic       ready;
  logic [1:0] grant;
  logic [0:0] hmaster;
  logic       mastlock;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  amba_ahb_arbiter #(.NM(2), .DM(0)) dut (
    .i_hclk(clk), .i_hreset(rst), .i_hbusreq(busreq), .i_hlock(lock),
    .i_htrans(trans), .i_hburst(burst), .i_hready(ready),
    .o_hgrant(grant), .o_hmaster(hmaster), .o_hmastlock(mastlock)
  );

  task automatic step(input logic [1:0] t, input logic [2:0] b, input logic r);
    trans = t; burst = b; ready = r;
    @(posedge clk); #1;
  endtask

  task automatic park_on_default();
    busreq = 2'b00; lock = 2'b00;
    step(IDLE, SINGLE, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL park grant: got %b want 01", grant); end
  endtask

  task automatic test_reset();
    rst = 1'b1; busreq = 2'b00; lock = 2'b00;
    step(IDLE, SINGLE, 1'b1);
    step(IDLE, SINGLE, 1'b1);
    rst = 1'b0;
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL reset grant: got %b want 01", grant); end
    n_vec++; if (hmaster !== 1'b0) begin n_bad++; $display("FAIL reset hmaster: got %0d want 0", hmaster); end
    n_vec++; if (mastlock !== 1'b0) begin n_bad++; $display("FAIL reset hmastlock: got %b want 0", mastlock); end
  endtask

  task automatic test_idle_round_robin();
    busreq = 2'b11;
    step(IDLE, SINGLE, 1'b1);
    n_vec++; if (grant !== 2'b10) begin n_bad++; $display("FAIL rr1 grant: got %b want 10", grant); end
    n_vec++; if (hmaster !== 1'b0) begin n_bad++; $display("FAIL rr1 hmaster: got %0d want 0", hmaster); end
    step(IDLE, SINGLE, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rr2 grant: got %b want 01", grant); end
    n_vec++; if (hmaster !== 1'b1) begin n_bad++; $display("FAIL rr2 hmaster: got %0d want 1", hmaster); end
    park_on_default();
  endtask

  task automatic test_incr4();
    busreq = 2'b11;
    step(NONSEQ, INCR4, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL incr4 beat1 grant: got %b want 01", grant); end
    step(SEQ, INCR4, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL incr4 beat2 grant: got %b want 01", grant); end
    step(SEQ, INCR4, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL incr4 beat3 grant: got %b want 01", grant); end
    step(SEQ, INCR4, 1'b1);
    n_vec++; if (grant !== 2'b10) begin n_bad++; $display("FAIL incr4 beat4 grant: got %b want 10", grant); end
    n_vec++; if (hmaster !== 1'b0) begin n_bad++; $display("FAIL incr4 beat4 hmaster: got %0d want 0", hmaster); end
    park_on_default();
  endtask

  task automatic test_incr4_stall_busy();
    busreq = 2'b11;
    step(NONSEQ, INCR4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(SEQ, INCR4, 1'b0);
      n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL stall%0d grant: got %b want 01", i, grant); end
    end
    step(SEQ, INCR4, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL stall beat2 grant: got %b want 01", grant); end
    step(BUSY, INCR4, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL busy grant: got %b want 01", grant); end
    step(SEQ, INCR4, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL stall beat3 grant: got %b want 01", grant); end
    step(SEQ, INCR4, 1'b1);
    n_vec++; if (grant !== 2'b10) begin n_bad++; $display("FAIL stall beat4 grant: got %b want 10", grant); end
    park_on_default();
  endtask

  task automatic test_lock();
    busreq = 2'b11; lock = 2'b01;
    for (int i = 0; i < 2; i++) begin
      step(NONSEQ, SINGLE, 1'b1);
      n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL lock%0d grant: got %b want 01", i, grant); end
      n_vec++; if (mastlock !== 1'b1) begin n_bad++; $display("FAIL lock%0d hmastlock: got %b want 1", i, mastlock); end
    end
    lock = 2'b00;
    step(NONSEQ, SINGLE, 1'b1);
    n_vec++; if (grant !== 2'b10) begin n_bad++; $display("FAIL unlock grant: got %b want 10", grant); end
    n_vec++; if (mastlock !== 1'b0) begin n_bad++; $display("FAIL unlock hmastlock: got %b want 0", mastlock); end
  endtask

  task automatic test_incr_undefined();
    busreq = 2'b11;
    step(NONSEQ, INCR, 1'b1);
    n_vec++; if (grant !== 2'b10) begin n_bad++; $display("FAIL incr nonseq grant: got %b want 10", grant); end
    step(SEQ, INCR, 1'b1);
    n_vec++; if (grant !== 2'b10) begin n_bad++; $display("FAIL incr seq grant: got %b want 10", grant); end
    busreq = 2'b01;
    step(SEQ, INCR, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL incr drop grant: got %b want 01", grant); end
    n_vec++; if (hmaster !== 1'b1) begin n_bad++; $display("FAIL incr drop hmaster: got %0d want 1", hmaster); end
  endtask

  task automatic test_park_and_reset_mid_burst();
    busreq = 2'b10;
    step(IDLE, SINGLE, 1'b1);
    n_vec++; if (grant !== 2'b10) begin n_bad++; $display("FAIL to1 grant: got %b want 10", grant); end
    busreq = 2'b00;
    step(IDLE, SINGLE, 1'b1);
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL park DM grant: got %b want 01", grant); end
    busreq = 2'b10;
    step(IDLE, SINGLE, 1'b1);
    busreq = 2'b11; lock = 2'b10;
    step(NONSEQ, INCR8, 1'b1);
    step(SEQ, INCR8, 1'b1);
    rst = 1'b1;
    step(SEQ, INCR8, 1'b0);
    rst = 1'b0;
    n_vec++; if (grant !== 2'b01) begin n_bad++; $display("FAIL rst-burst grant: got %b want 01", grant); end
    n_vec++; if (hmaster !== 1'b0) begin n_bad++; $display("FAIL rst-burst hmaster: got %0d want 0", hmaster); end
    n_vec++; if (mastlock !== 1'b0) begin n_bad++; $display("FAIL rst-burst hmastlock: got %b want 0", mastlock); end
    busreq = 2'b10; lock = 2'b00;
    step(IDLE, SINGLE, 1'b1);
    n_vec++; if (grant !== 2'b10) begin n_bad++; $display("FAIL post-rst cnt grant: got %b want 10", grant); end
  endtask

  initial begin
    rst = 1'b1; busreq = 2'b00; lock = 2'b00; trans = IDLE; burst = SINGLE; ready = 1'b1;
    test_reset();
    test_idle_round_robin();
    test_incr4();
    test_incr4_stall_busy();
    test_lock();
    test_incr_undefined();
    test_park_and_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
